// File: rtl/ysyx_ifu_fetch.sv
// ysyx_ifu_fetch: in-order fetch, one outstanding bus read, QDEPTH-entry queue to decode; rsp_valid -> valid_o in 1 cycle.
// Fetch stalls when queue + in-flight reach QDEPTH or next_ready holds the head; YSYX_IFU_BYPASS_EN adds same-cycle bypass when empty.
module ysyx_ifu_fetch #(
  parameter int BIT_W = 32,
  parameter logic [BIT_W-1:0] RESET_PC = 32'h8000_0000,
  parameter int QDEPTH = 2,
  parameter int BR_CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [BIT_W-1:0] flush_pc,
  input  logic             branch_retire,
  output logic             req_valid,
  output logic [BIT_W-1:0] req_addr,
  input  logic             req_ready,
  input  logic             rsp_valid,
  input  logic [31:0]      rsp_data,
  input  logic             rsp_err,
  output logic [31:0]      inst_o,
  output logic [BIT_W-1:0] pc_o,
  output logic             speculation_o,
  output logic             valid_o,
  input  logic             next_ready
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [BIT_W-1:0]    pc;
  logic [BIT_W-1:0]    req_pc;
  logic                drop;
  logic [BR_CNT_W-1:0] br_cnt;

  logic [31:0]      q_inst [QDEPTH];
  logic [BIT_W-1:0] q_pc   [QDEPTH];
  logic             q_spec [QDEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  logic        q_empty, q_pop, enq, deq, bypass;
  logic        rsp_take, rsp_spec, rsp_is_br, br_full, br_inc, br_dec;
  logic [31:0] rsp_inst;

  assign q_empty   = (count == '0);
  assign br_full   = &br_cnt;
  assign rsp_take  = (state == S_WAIT) && rsp_valid && !drop && !flush;
  assign rsp_inst  = rsp_err ? EBREAK : rsp_data;
  assign rsp_spec  = (br_cnt != '0);
  assign rsp_is_br = (rsp_inst[6:0] == 7'b1100011) || (rsp_inst[6:0] == 7'b1100111);

`ifdef YSYX_IFU_BYPASS_EN
  assign bypass = q_empty && rsp_take;
`else
  assign bypass = 1'b0;
`endif

  assign valid_o = (!q_empty || bypass) && !flush;
  assign deq     = valid_o && next_ready;
  assign q_pop   = deq && !q_empty;
  // A bypassed response taken by decode this cycle never occupies a slot.
  assign enq     = rsp_take && !(bypass && next_ready);
  assign br_inc  = rsp_take && rsp_is_br;
  assign br_dec  = branch_retire;

  assign req_addr = {req_pc[BIT_W-1:2], 2'b00};

  always_comb begin
    inst_o        = '0;
    pc_o          = '0;
    speculation_o = 1'b0;
    if (bypass) begin
      inst_o        = rsp_inst;
      pc_o          = req_pc;
      speculation_o = rsp_spec;
    end else if (!q_empty) begin
      inst_o        = q_inst[rd_ptr];
      pc_o          = q_pc[rd_ptr];
      speculation_o = q_spec[rd_ptr];
    end
  end

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (!flush && (count < CNT_W'(QDEPTH)) && !br_full)
          state_nxt = S_REQ;
      end
      S_REQ: begin
        req_valid = 1'b1;
        if (req_ready)
          state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_valid)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      drop   <= 1'b0;
      br_cnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && state_nxt == S_REQ)
        req_pc <= pc;

      // After a flush, pc already holds the redirect target; the stale request must not bump it.
      if (flush)
        pc <= flush_pc;
      else if (state == S_REQ && req_ready && !drop)
        pc <= pc + BIT_W'(4);

      if (flush)
        drop <= (state == S_REQ) || (state == S_WAIT && !rsp_valid);
      else if (state == S_WAIT && rsp_valid)
        drop <= 1'b0;

      if (flush)
        br_cnt <= '0;
      else if (br_inc && !br_dec && !br_full)
        br_cnt <= br_cnt + BR_CNT_W'(1);
      else if (!br_inc && br_dec && br_cnt != '0)
        br_cnt <= br_cnt - BR_CNT_W'(1);

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq)
          wr_ptr <= wr_ptr + PTR_W'(1);
        if (q_pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(enq) - CNT_W'(q_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_inst[wr_ptr] <= rsp_inst;
      q_pc[wr_ptr]   <= req_pc;
      q_spec[wr_ptr] <= rsp_spec;
    end
  end

endmodule
